// File: rtl/blink_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : blink_scheduler
// Purpose  : Table-driven LED blink sequencer. A small table of on/off tick
//            counts is written over a valid/ready port while idle. On start
//            the table is walked entry by entry. blink_out is driven high for
//            on_ticks and low for off_ticks. A tick is a rising edge of
//            count[TICK_BIT].
// Revision : 1.0 - initial release
// ============================================================================
module blink_scheduler #(
   parameter int TICK_BIT = 7,
   parameter int STEPS    = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [15:0]                count,
   input  logic                       cfg_valid,
   output logic                       cfg_ready,
   input  logic [$clog2(STEPS)-1:0]   cfg_addr,
   input  logic [7:0]                 cfg_data,
   input  logic                       start,
   input  logic                       stop,
   input  logic                       loop,
   output logic                       blink_out,
   output logic [$clog2(STEPS)-1:0]   step_idx,
   output logic                       busy,
   output logic                       done
);

   localparam int              C_AW       = $clog2(STEPS);
   localparam logic [C_AW-1:0] C_LAST_IDX = C_AW'(STEPS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_ON   = 2'd2,
      ST_OFF  = 2'd3
   } state_t;

   // Registered state
   state_t          r_state;
   logic [7:0]      r_table [STEPS];
   logic [C_AW-1:0] r_idx;
   logic [3:0]      r_phase;
   logic            r_blink;
   logic            r_done;
   logic            r_prev_bit;

   // Combinational next-state signals
   state_t          w_next_state;
   logic [C_AW-1:0] w_next_idx;
   logic [3:0]      w_next_phase;
   logic            w_done_set;
   logic            w_advance;
   logic            w_wrap;
   logic            w_tick;
   logic            w_cfg_write;
   logic [7:0]      w_entry;
   logic [3:0]      w_on_ticks;
   logic [3:0]      w_off_ticks;

   // Only one bit of the counter bus is of interest; fold the rest away.
   logic            w_unused_count;
   assign w_unused_count = ^count;

   // The table is read-only once a sequence is running, so the current
   // entry is stable for the whole step.
   assign w_entry     = r_table[r_idx];
   assign w_on_ticks  = w_entry[7:4];
   assign w_off_ticks = w_entry[3:0];

   assign w_tick      = count[TICK_BIT] & ~r_prev_bit;
   assign w_cfg_write = cfg_valid && (r_state == ST_IDLE);

   assign cfg_ready = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign blink_out = r_blink;
   assign step_idx  = r_idx;
   assign done      = r_done;

   // Keep the previous tick bit so a rising edge can be found. Loading the
   // live bit out of reset avoids a false tick on the first cycle.
   always_ff @(posedge clk) begin
      r_prev_bit <= count[TICK_BIT];
   end

   // Step table: cleared by reset, written only while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STEPS; i++) begin
            r_table[i] <= 8'h00;
         end
      end else if (w_cfg_write) begin
         r_table[cfg_addr] <= cfg_data;
      end
   end

   // Next state, step index, phase counter and done request.
   always_comb begin
      w_next_state = r_state;
      w_next_idx   = r_idx;
      w_next_phase = r_phase;
      w_done_set   = 1'b0;
      w_advance    = 1'b0;
      w_wrap       = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (start && !stop) begin
               w_next_state = ST_LOAD;
               w_next_idx   = '0;
            end
         end
         ST_LOAD: begin
            if (w_entry == 8'h00) begin
               // Terminator: an empty table at entry 0 always ends the run,
               // otherwise it behaves like running off the end of the table.
               if (r_idx == '0) begin
                  w_next_state = ST_IDLE;
                  w_next_phase = 4'd0;
                  w_done_set   = 1'b1;
               end else begin
                  w_wrap = 1'b1;
               end
            end else if (w_on_ticks != 4'd0) begin
               w_next_phase = w_on_ticks;
               w_next_state = ST_ON;
            end else begin
               w_next_phase = w_off_ticks;
               w_next_state = ST_OFF;
            end
         end
         ST_ON: begin
            if (w_tick) begin
               if (r_phase == 4'd1) begin
                  if (w_off_ticks != 4'd0) begin
                     w_next_phase = w_off_ticks;
                     w_next_state = ST_OFF;
                  end else begin
                     w_advance = 1'b1;
                  end
               end else begin
                  w_next_phase = r_phase - 4'd1;
               end
            end
         end
         ST_OFF: begin
            if (w_tick) begin
               if (r_phase == 4'd1) begin
                  w_advance = 1'b1;
               end else begin
                  w_next_phase = r_phase - 4'd1;
               end
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase

      // Move to the next entry, or wrap after the last one.
      if (w_advance) begin
         if (r_idx == C_LAST_IDX) begin
            w_wrap = 1'b1;
         end else begin
            w_next_idx   = r_idx + C_AW'(1);
            w_next_state = ST_LOAD;
         end
      end

      // Wrap either restarts at entry 0 or ends the sequence naturally.
      if (w_wrap) begin
         w_next_idx = '0;
         if (loop) begin
            w_next_state = ST_LOAD;
         end else begin
            w_next_state = ST_IDLE;
            w_next_phase = 4'd0;
            w_done_set   = 1'b1;
         end
      end

      // Abort wins over anything else scheduled this cycle and is silent.
      if (stop && (r_state != ST_IDLE)) begin
         w_next_state = ST_IDLE;
         w_next_idx   = '0;
         w_next_phase = 4'd0;
         w_done_set   = 1'b0;
      end
   end

   // Control registers; blink_out is high exactly while the ON state is held.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_phase <= 4'd0;
         r_blink <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_idx   <= w_next_idx;
         r_phase <= w_next_phase;
         r_blink <= (w_next_state == ST_ON);
         r_done  <= w_done_set;
      end
   end

endmodule
`default_nettype wire

// File: doc/blink_scheduler.md
# blink_scheduler

Sequences the LED blinker from the free-running 16-bit `count` bus. Holds a small table of on/off step durations, loaded over a valid/ready write port. On `start` it walks the table one step at a time, driving `blink_out` high and low for a programmed number of ticks. A tick is a rising edge of a selected `count` bit. The block sits between the counter and `uo_out[0]` in the top level and replaces the fixed-offset blinker.

## Interface
- `TICK_BIT`, default 7: index of the `count` bit whose rising edge is one tick (0..15).
- `STEPS`, default 4: number of table entries, a power of two, 2..16.
- `clk` input, 1 bit: the single clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `count` input, 16 bits: free-running counter value.
- `cfg_valid` input, 1 bit: a table write is offered.
- `cfg_ready` output, 1 bit: a table write can be accepted; high only in IDLE.
- `cfg_addr` input, log2(STEPS) bits: table entry to write.
- `cfg_data` input, 8 bits: `[7:4]` is on_ticks, `[3:0]` is off_ticks.
- `start` input, 1 bit: one-cycle request to begin sequencing.
- `stop` input, 1 bit: synchronous abort.
- `loop` input, 1 bit: sampled at each wrap; 1 means restart at entry 0.
- `blink_out` output, 1 bit: registered LED drive.
- `step_idx` output, log2(STEPS) bits: registered index of the current entry.
- `busy` output, 1 bit: high when state is not IDLE.
- `done` output, 1 bit: one-cycle pulse when a sequence ends naturally.

## Operation
- States: IDLE, LOAD, ON, OFF.
- Reset values:
  - state is IDLE.
  - all table entries are 8'h00.
  - `blink_out`, `step_idx`, `busy`, `done` and the phase counter are 0.
  - `prev_bit` is loaded with `count[TICK_BIT]`.
  - `cfg_ready` is 1.
- Table write:
  - A write occurs on a cycle with `cfg_valid && cfg_ready`.
  - The entry at `cfg_addr` takes `cfg_data` at the clock edge.
  - Outside IDLE the table is read-only and `cfg_ready` is 0.
- Tick detection:
  - `prev_bit` is registered every cycle.
  - `tick = count[TICK_BIT] & ~prev_bit`.
- IDLE:
  - `start` with `stop` low sets `step_idx` to 0 and moves to LOAD.
  - `stop` has priority over `start`.
- LOAD (one cycle) examines entry[`step_idx`]:
  - Entry is 8'h00 (terminator) and `step_idx` is 0: go to IDLE and pulse `done`, regardless of `loop`.
  - Entry is 8'h00 and `step_idx` is not 0: wrap.
  - on_ticks is not 0: load the phase counter with on_ticks and go to ON.
  - on_ticks is 0: load the phase counter with off_ticks and go to OFF.
- ON:
  - `blink_out` is 1.
  - Each tick decrements the phase counter.
  - A tick while the counter equals 1 leaves the state. If off_ticks is not 0, load it and go to OFF; otherwise advance.
- OFF:
  - `blink_out` is 0.
  - The phase counter runs as in ON; when it expires, advance.
- Advance:
  - If `step_idx == STEPS-1`, wrap.
  - Otherwise increment `step_idx` and go to LOAD.
- Wrap:
  - If `loop` is 1, set `step_idx` to 0 and go to LOAD.
  - If `loop` is 0, go to IDLE, pulse `done`, and set `step_idx` to 0.
- `stop` in any non-IDLE state:
  - Next cycle the state is IDLE, `blink_out` is 0 and `step_idx` is 0.
  - `done` is not pulsed.
  - `stop` overrides any transition due in the same cycle.
- `start` outside IDLE is ignored.
- Ticks during IDLE and LOAD are not counted.

## Timing
- `start` sampled at edge N:
  - LOAD during cycle N+1.
  - ON or OFF from edge N+2; `blink_out` becomes valid at N+2.
- Phase length is k counted ticks. The first tick after entry may arrive early, so the phase lasts between (k-1)·2^(TICK_BIT+1)+1 and k·2^(TICK_BIT+1) cycles.
- An ON-to-OFF transition takes 0 extra cycles.
- Each step change adds one LOAD cycle, during which `blink_out` is 0.
- `done` is high for exactly the one cycle following the edge that enters IDLE.
- `rst` asserted mid-sequence:
  - Outputs return to reset values at the next edge.
  - The table is cleared.

## Test plan
- Reset and write:
  - Stimulus: assert `rst` 2 cycles; write entry0=8'h21 and entry1=8'h12 with `cfg_valid` held.
  - Required: all outputs 0 and `cfg_ready` 1 after reset; each write accepted in one cycle.
- Single pass:
  - Stimulus: TICK_BIT=2, `count` incrementing, `loop`=0, entries 8'h21, 8'h12, 8'h00, 8'h00; pulse `start`.
  - Required: `blink_out` high for 2 ticks then low for 1 tick at idx 0; high for 1 tick then low for 2 ticks at idx 1; terminator then returns to IDLE; `done` pulses once.
- Loop and full table:
  - Stimulus: all 4 entries 8'h11, `loop`=1.
  - Required: `step_idx` sequence 0,1,2,3,0,1…; `done` never asserts.
- Stop priority:
  - Stimulus: assert `stop` in ON on the same cycle a tick expires the phase.
  - Required: IDLE next cycle, `blink_out` 0, no `done`.
  - Stimulus: `start` and `stop` together in IDLE.
  - Required: state stays IDLE.
- Zero phases:
  - Stimulus: entry0=8'h00 with `loop`=1.
  - Required: `done` 2 cycles after `start`.
  - Stimulus: entry0=8'h03.
  - Required: no ON phase; OFF lasts 3 ticks.
- Config lockout:
  - Stimulus: `cfg_valid` held while busy.
  - Required: `cfg_ready` 0 and the table unchanged; the write is accepted on the first IDLE cycle.
